// File: rtl/dport_sram_resp_pkg.sv
// Shared types for the data-port SRAM responder: FSM states,
// request kinds and the buffered request entry layout.
package dport_sram_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ISSUE,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    K_READ,
    K_WRITE,
    K_MAINT
  } kind_t;

  // Word index is kept at full 30-bit width; the top truncates it.
  typedef struct packed {
    logic [29:0] idx;
    logic [31:0] data;
    logic [3:0]  wr;
    kind_t       kind;
    logic [10:0] tag;
    logic        oor;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  function automatic kind_t decode_kind(
    input logic [3:0] wr,
    input logic       rd
  );
    kind_t k;
    k = K_MAINT;
    unique case (1'b1)
      (|wr):        k = K_WRITE;
      (~|wr && rd): k = K_READ;
      default:      k = K_MAINT;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/dport_sram_resp_fifo.sv
// Parameterised synchronous FIFO for buffered data-port requests.
// DEPTH must be a power of two so the pointers wrap naturally.
module dport_sram_resp_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  assign dout  = mem[rp];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/dport_sram_resp.sv
// Data-port responder: queues tagged requests and serves them in order
// from a single-port SRAM. Range checking via DPORT_SRAM_RESP_ERR_EN.
module dport_sram_resp
  import dport_sram_resp_pkg::*;
#(
  parameter int          ADDR_W      = 14,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          WAIT_STATES = 0,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_d_addr_i,
  input  logic [31:0]       mem_d_data_wr_i,
  input  logic              mem_d_rd_i,
  input  logic [3:0]        mem_d_wr_i,
  input  logic              mem_d_cacheable_i,
  input  logic [10:0]       mem_d_req_tag_i,
  input  logic              mem_d_invalidate_i,
  input  logic              mem_d_writeback_i,
  input  logic              mem_d_flush_i,
  output logic              mem_d_accept_o,
  output logic              mem_d_ack_o,
  output logic              mem_d_error_o,
  output logic [10:0]       mem_d_resp_tag_o,
  output logic [31:0]       mem_d_data_rd_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_rd_o,
  output logic [3:0]        sram_wr_o,
  output logic [31:0]       sram_data_o,
  input  logic [31:0]       sram_data_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] WS_LD =
    (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  logic               req;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic               more;
  logic               oor;
  logic               unused_ok;
  logic [CW-1:0]      count;
  logic [32:0]        off;
  logic [ENTRY_W-1:0] head_v;
  entry_t             in_e;
  entry_t             head;
  state_t             state;
  state_t             nxt;
  state_t             go;
  logic [3:0]         wcnt;

  assign req = mem_d_rd_i | (|mem_d_wr_i) | mem_d_flush_i
             | mem_d_invalidate_i | mem_d_writeback_i;

  // Gated by rst so the core sees no accept while held in reset.
  assign mem_d_accept_o = rst & ~full;
  assign push = req & mem_d_accept_o;
  assign pop  = (state == ST_RESP);

  assign off = {1'b0, mem_d_addr_i} - {1'b0, BASE_ADDR};

`ifdef DPORT_SRAM_RESP_ERR_EN
  assign oor = off[32] | (|(off[31:2] >> ADDR_W));
`else
  assign oor = 1'b0;
`endif

  always_comb begin
    in_e      = '0;
    in_e.idx  = off[31:2];
    in_e.data = mem_d_data_wr_i;
    in_e.wr   = mem_d_wr_i;
    in_e.kind = decode_kind(mem_d_wr_i, mem_d_rd_i);
    in_e.tag  = mem_d_req_tag_i;
    in_e.oor  = oor;
  end

  dport_sram_resp_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in_e),
    .dout  (head_v),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign head = entry_t'(head_v);
  assign go   = (WAIT_STATES != 0) ? ST_WAIT : ST_ISSUE;
  // A same-cycle push keeps the pipeline busy without an idle bubble.
  assign more = (count > CW'(1)) | push;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      wcnt  <= '0;
    end else begin
      state <= nxt;
      if (nxt == ST_WAIT && state != ST_WAIT) wcnt <= WS_LD;
      else if (state == ST_WAIT)              wcnt <= wcnt - 4'd1;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:  if (!empty) nxt = go;
      ST_WAIT:  if (wcnt == 4'd0) nxt = ST_ISSUE;
      ST_ISSUE: nxt = ST_RESP;
      ST_RESP:  nxt = more ? go : ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sram_addr_o      = '0;
    sram_rd_o        = 1'b0;
    sram_wr_o        = 4'b0;
    sram_data_o      = '0;
    mem_d_ack_o      = 1'b0;
    mem_d_error_o    = 1'b0;
    mem_d_resp_tag_o = '0;
    mem_d_data_rd_o  = '0;
    unique case (state)
      ST_ISSUE: begin
        sram_addr_o = head.idx[ADDR_W-1:0];
        sram_rd_o   = (head.kind == K_READ) & ~head.oor;
        if (head.kind == K_WRITE && !head.oor) begin
          sram_wr_o   = head.wr;
          sram_data_o = head.data;
        end
      end
      ST_RESP: begin
        mem_d_ack_o      = 1'b1;
        mem_d_error_o    = head.oor;
        mem_d_resp_tag_o = head.tag;
        if (head.kind == K_READ && !head.oor)
          mem_d_data_rd_o = sram_data_i;
      end
      default: ;
    endcase
  end

  assign unused_ok = ^{mem_d_cacheable_i, off[32], off[1:0],
                       head.idx[29:ADDR_W]};

endmodule

// File: tb/tb_dport_sram_resp.sv
// Directed bench for dport_sram_resp: one instance with no wait states,
// one with two wait states, each backed by a behavioural SRAM.
`timescale 1ns/1ps
module tb_dport_sram_resp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        rd    [2];
  logic [3:0]  wr    [2];
  logic        cach  [2];
  logic        inv   [2];
  logic        wb    [2];
  logic        fl    [2];
  logic [10:0] rtag  [2];
  logic        acc   [2];
  logic        ack   [2];
  logic        err   [2];
  logic [10:0] tag   [2];
  logic [31:0] rdata [2];
  logic [13:0] saddr [2];
  logic        srd   [2];
  logic [3:0]  swr   [2];
  logic [31:0] sdo   [2];
  logic [31:0] sdi   [2];

  logic [31:0] mem [2][16384];
  logic        pl_en;
  int          pl_g;
  logic [13:0] pl_idx;
  logic [31:0] pl_val;

  int rd_cnt  [2];
  int wr_cnt  [2];
  int ack_cnt [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dport_sram_resp #(.WAIT_STATES(g * 2)) u_dut (
      .clk                (clk),
      .rst                (rst),
      .mem_d_addr_i       (addr[g]),
      .mem_d_data_wr_i    (wdata[g]),
      .mem_d_rd_i         (rd[g]),
      .mem_d_wr_i         (wr[g]),
      .mem_d_cacheable_i  (cach[g]),
      .mem_d_req_tag_i    (rtag[g]),
      .mem_d_invalidate_i (inv[g]),
      .mem_d_writeback_i  (wb[g]),
      .mem_d_flush_i      (fl[g]),
      .mem_d_accept_o     (acc[g]),
      .mem_d_ack_o        (ack[g]),
      .mem_d_error_o      (err[g]),
      .mem_d_resp_tag_o   (tag[g]),
      .mem_d_data_rd_o    (rdata[g]),
      .sram_addr_o        (saddr[g]),
      .sram_rd_o          (srd[g]),
      .sram_wr_o          (swr[g]),
      .sram_data_o        (sdo[g]),
      .sram_data_i        (sdi[g])
    );
  end

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (srd[g]) sdi[g] <= mem[g][saddr[g]];
      for (int b = 0; b < 4; b++)
        if (swr[g][b]) mem[g][saddr[g]][8*b +: 8] <= sdo[g][8*b +: 8];
    end
    if (pl_en) mem[pl_g][pl_idx] <= pl_val;
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (srd[g])        rd_cnt[g]++;
      if (swr[g] != 4'b0) wr_cnt[g]++;
      if (ack[g])        ack_cnt[g]++;
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wr;
    logic        rd;
    logic [2:0]  mnt;
    logic [10:0] tag;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_rds;
    int          exp_wrs;
  } vec_t;

  vec_t vt [13];

  logic [31:0] s_addr [8];
  logic [31:0] s_data [8];
  logic [3:0]  s_wr   [8];
  logic        s_rd   [8];
  logic [2:0]  s_mnt  [8];
  logic [10:0] s_tag  [8];
  int          a_cyc  [8];
  logic [10:0] a_tag  [8];
  logic [31:0] a_data [8];
  logic        a_err  [8];
  int          p_cyc  [8];
  int          nack;
  int          first_low;
  int          checks;
  int          errors;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int g);
    rd[g] = 1'b0; wr[g] = 4'b0; fl[g] = 1'b0; inv[g] = 1'b0;
    wb[g] = 1'b0; cach[g] = 1'b0; addr[g] = '0; wdata[g] = '0;
    rtag[g] = '0;
  endtask

  task automatic preload(input int g, input logic [13:0] idx,
                         input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_g = g; pl_idx = idx; pl_val = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Cycle k = 0 is the cycle the first request is presented.
  task automatic run_stream(input int g, input int n, input int kmax);
    int  i;
    bit  a;
    i = 0; nack = 0; first_low = -1;
    for (int k = 0; k < kmax; k++) begin
      @(negedge clk);
      if (ack[g] && nack < 8) begin
        a_cyc[nack]  = k;
        a_tag[nack]  = tag[g];
        a_data[nack] = rdata[g];
        a_err[nack]  = err[g];
        nack++;
      end
      a = 1'b0;
      if (i < n) begin
        addr[g] = s_addr[i]; wdata[g] = s_data[i]; wr[g] = s_wr[i];
        rd[g] = s_rd[i]; fl[g] = s_mnt[i][2]; inv[g] = s_mnt[i][1];
        wb[g] = s_mnt[i][0]; rtag[g] = s_tag[i]; cach[g] = 1'b1;
        a = acc[g];
        if (a) p_cyc[i] = k;
        else if (first_low < 0) first_low = k;
      end else begin
        idle(g);
      end
      @(posedge clk);
      if (a) i++;
    end
    idle(g);
  endtask

  task automatic set_req(input int i, input logic [31:0] ad,
                         input logic [31:0] d, input logic [3:0] w,
                         input logic r, input logic [2:0] m,
                         input logic [10:0] t);
    s_addr[i] = ad; s_data[i] = d; s_wr[i] = w;
    s_rd[i] = r; s_mnt[i] = m; s_tag[i] = t;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int b_rd, b_wr, b_ack;
    checks = 0; errors = 0; pl_en = 1'b0; pl_g = 0;
    pl_idx = '0; pl_val = '0;
    idle(0); idle(1);

    vt[0]  = '{32'h8000_4800, 0, 4'h0, 1'b1, 3'b000, 11'h005,
               32'hC0DE_000D, 1'b0, 1, 0};
    vt[1]  = '{32'h8000_4804, 32'hAAAA_AAAA, 4'hF, 1'b0, 3'b000, 11'h010,
               0, 1'b0, 0, 1};
    vt[2]  = '{32'h8000_4804, 32'h5555_5555, 4'h3, 1'b0, 3'b000, 11'h011,
               0, 1'b0, 0, 1};
    vt[3]  = '{32'h8000_4804, 0, 4'h0, 1'b1, 3'b000, 11'h012,
               32'hAAAA_5555, 1'b0, 1, 0};
    vt[4]  = '{32'h8000_4807, 0, 4'h0, 1'b1, 3'b000, 11'h7FF,
               32'hAAAA_5555, 1'b0, 1, 0};
    vt[5]  = '{32'h8000_4800, 0, 4'h0, 1'b0, 3'b100, 11'h3FF,
               0, 1'b0, 0, 0};
    vt[6]  = '{32'h8000_4800, 0, 4'h0, 1'b0, 3'b010, 11'h001,
               0, 1'b0, 0, 0};
    vt[7]  = '{32'h8000_4800, 0, 4'h0, 1'b0, 3'b001, 11'h002,
               0, 1'b0, 0, 0};
    vt[8]  = '{32'h8000_0010, 32'h00EE_0000, 4'h4, 1'b1, 3'b000, 11'h030,
               0, 1'b0, 0, 1};
    vt[9]  = '{32'h8000_0010, 0, 4'h0, 1'b1, 3'b000, 11'h031,
               32'h11EE_3344, 1'b0, 1, 0};
    vt[11] = '{32'h8000_FFFC, 0, 4'h0, 1'b1, 3'b000, 11'h040,
               32'hDEAD_BEEF, 1'b0, 1, 0};
`ifdef DPORT_SRAM_RESP_ERR_EN
    vt[10] = '{32'h7000_0000, 0, 4'h0, 1'b1, 3'b000, 11'h020,
               0, 1'b1, 0, 0};
    vt[12] = '{32'h8001_0000, 0, 4'h0, 1'b1, 3'b000, 11'h041,
               0, 1'b1, 0, 0};
`else
    vt[10] = '{32'h7000_0000, 0, 4'h0, 1'b1, 3'b000, 11'h020,
               32'h1234_5678, 1'b0, 1, 0};
    vt[12] = '{32'h8001_0000, 0, 4'h0, 1'b1, 3'b000, 11'h041,
               32'h1234_5678, 1'b0, 1, 0};
`endif

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("accept_in_reset", acc[0], 0);
    chk("ack_in_reset", {ack[0], err[0], tag[0], rdata[0]}, 0);
    rst = 1'b1;
    #1 chk("accept_after_reset", acc[0], 1);

    preload(0, 14'h1200, 32'hC0DE_000D);
    preload(0, 14'h0000, 32'h1234_5678);
    preload(0, 14'h0004, 32'h1122_3344);
    preload(0, 14'h3FFF, 32'hDEAD_BEEF);
    for (int i = 0; i < 6; i++)
      preload(1, 14'h0100 + 14'(i), 32'hB000_0000 + 32'(i));

    for (int v = 0; v < 13; v++) begin
      set_req(0, vt[v].addr, vt[v].data, vt[v].wr, vt[v].rd,
              vt[v].mnt, vt[v].tag);
      b_rd = rd_cnt[0]; b_wr = wr_cnt[0];
      run_stream(0, 1, 8);
      @(negedge clk);
      chk($sformatf("v%0d_nack", v), nack, 1);
      chk($sformatf("v%0d_latency", v), a_cyc[0], 3);
      chk($sformatf("v%0d_tag", v), a_tag[0], vt[v].tag);
      chk($sformatf("v%0d_data", v), a_data[0], vt[v].exp_data);
      chk($sformatf("v%0d_err", v), a_err[0], vt[v].exp_err);
      chk($sformatf("v%0d_rd_strobes", v), rd_cnt[0] - b_rd,
          vt[v].exp_rds);
      chk($sformatf("v%0d_wr_strobes", v), wr_cnt[0] - b_wr,
          vt[v].exp_wrs);
    end

    // Back-to-back burst, including a push in the same cycle as a pop.
    set_req(0, 32'h8000_0100, 32'hAAAA_AAAA, 4'hF, 1'b0, 3'b000, 11'h101);
    set_req(1, 32'h8000_0100, 32'h5555_5555, 4'h3, 1'b0, 3'b000, 11'h102);
    set_req(2, 32'h8000_0100, 0, 4'h0, 1'b1, 3'b000, 11'h103);
    set_req(3, 32'h8000_0100, 0, 4'h0, 1'b0, 3'b100, 11'h104);
    run_stream(0, 4, 14);
    chk("burst_nack", nack, 4);
    chk("burst_first_low", first_low, -1);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("burst_push%0d", j), p_cyc[j], j);
      chk($sformatf("burst_ack_cyc%0d", j), a_cyc[j], 3 + 2 * j);
      chk($sformatf("burst_tag%0d", j), a_tag[j], 11'h101 + 11'(j));
      chk($sformatf("burst_data%0d", j), a_data[j],
          (j == 2) ? 32'hAAAA_5555 : 32'h0);
    end

    // Six held reads into a 4-deep FIFO with two wait states.
    for (int j = 0; j < 6; j++)
      set_req(j, 32'h8000_0400 + 32'(4 * j), 0, 4'h0, 1'b1, 3'b000,
              11'h200 + 11'(j));
    run_stream(1, 6, 32);
    chk("tput_nack", nack, 6);
    chk("tput_accept_drop", first_low, 4);
    chk("tput_push4", p_cyc[4], 6);
    chk("tput_push5", p_cyc[5], 10);
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("tput_ack_cyc%0d", j), a_cyc[j], 5 + 4 * j);
      chk($sformatf("tput_tag%0d", j), a_tag[j], 11'h200 + 11'(j));
      chk($sformatf("tput_data%0d", j), a_data[j],
          32'hB000_0000 + 32'(j));
    end

    // Reset while two reads wait in the queue.
    @(negedge clk);
    rd[1] = 1'b1; addr[1] = 32'h8000_0400; rtag[1] = 11'h300;
    @(negedge clk);
    addr[1] = 32'h8000_0404; rtag[1] = 11'h301;
    @(negedge clk);
    idle(1);
    b_rd = rd_cnt[1]; b_wr = wr_cnt[1]; b_ack = ack_cnt[1];
    rst = 1'b0;
    #1;
    chk("rst_accept_low", acc[1], 0);
    chk("rst_outputs_zero", {ack[1], err[1], tag[1], rdata[1]}, 0);
    chk("rst_sram_zero", {srd[1], swr[1]}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_release_accept", acc[1], 1);
    repeat (10) @(negedge clk);
    chk("rst_no_ack", ack_cnt[1] - b_ack, 0);
    chk("rst_no_rd", rd_cnt[1] - b_rd, 0);
    chk("rst_no_wr", wr_cnt[1] - b_wr, 0);
    set_req(0, 32'h8000_0408, 0, 4'h0, 1'b1, 3'b000, 11'h310);
    run_stream(1, 1, 10);
    chk("post_rst_nack", nack, 1);
    chk("post_rst_latency", a_cyc[0], 5);
    chk("post_rst_tag", a_tag[0], 11'h310);
    chk("post_rst_data", a_data[0], 32'hB000_0002);
    chk("post_rst_err", a_err[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
